// File: rtl/act_pkg.sv
// Shared types and helpers for the activation writeback path and readers of the
// activation memory.
package act_pkg;

  localparam int unsigned ACT_W  = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned CNT_W  = ROW_W + 1;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wb_state_t;

  // Activation memory address: {bank, 4'b0, row, 3'b0}
  function automatic logic [ADDR_W-1:0] pack_waddr(input logic b,
                                                   input logic [ROW_W-1:0] row);
    return {b, 4'b0000, row, 3'b000};
  endfunction

endpackage

// File: rtl/act_quant.sv
// Combinational rescale: round-and-shift of the accumulator, then optional ReLU
// (ACT_WRITEBACK_RELU_EN) and saturation to a 16-bit activation.
module act_quant
  import act_pkg::*;
#(
  parameter int unsigned SHIFT = 8
) (
  input  logic        [ACC_W-1:0] acc_i,
  output logic signed [ACC_W:0]   scaled_c_o,
  input  logic signed [ACC_W:0]   scaled_i,
  output logic        [ACT_W-1:0] act_c_o
);

  localparam int unsigned SW = ACC_W + 1;
  localparam logic signed [ACC_W:0] ROUND_OFF =
      (SHIFT == 0) ? '0 : $signed(SW'(1) << (SHIFT - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = $signed(SW'(32767));
  localparam logic signed [ACC_W:0] SAT_MIN = -$signed(SW'(32768));

  logic signed [ACC_W:0] sum_c;
  logic signed [ACC_W:0] rect_c;

  // Stage 1: sign-extend to 33 bits so the rounding add cannot overflow
  always_comb begin
    sum_c      = $signed({acc_i[ACC_W-1], acc_i}) + ROUND_OFF;
    scaled_c_o = sum_c >>> SHIFT;
  end

  always_comb begin
`ifdef ACT_WRITEBACK_RELU_EN
    rect_c = scaled_i[ACC_W] ? '0 : scaled_i;
`else
    rect_c = scaled_i;
`endif
    if (rect_c > SAT_MAX) begin
      act_c_o = 16'h7fff;
    end else if (rect_c < SAT_MIN) begin
      act_c_o = 16'h8000;
    end else begin
      act_c_o = rect_c[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/act_writeback.sv
// Writeback stage: accepts accumulator words, quantises them in a 2-stage pipe and
// writes consecutive activation rows. ReLU build option: ACT_WRITEBACK_RELU_EN.
module act_writeback
  import act_pkg::*;
#(
  parameter int unsigned SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bank,
  input  logic [ROW_W-1:0]  base_idx,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_data,
  output logic              we,
  output logic [ACT_W-1:0]  wdata,
  output logic [ADDR_W-1:0] waddr,
  output logic              busy,
  output logic              done
);

  wb_state_t             state_q;
  logic                  bank_q;
  logic [ROW_W-1:0]      row_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      acc_cnt_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic                  in_ready_q;
  logic                  s1_valid_q;
  logic signed [ACC_W:0] s1_q;
  logic                  we_q;
  logic [ACT_W-1:0]      wdata_q;
  logic [ADDR_W-1:0]     waddr_q;
  logic                  busy_q;
  logic                  done_q;

  logic signed [ACC_W:0] s1_d;
  logic [ACT_W-1:0]      act_d;
  logic                  accept_c;

  assign accept_c = in_valid && in_ready_q;

  act_quant #(.SHIFT(SHIFT)) u_quant (
    .acc_i      (in_data),
    .scaled_c_o (s1_d),
    .scaled_i   (s1_q),
    .act_c_o    (act_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bank_q     <= 1'b0;
      row_q      <= '0;
      count_q    <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      in_ready_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      s1_valid_q <= accept_c;

      // Stage 1 capture; ready drops as soon as the last word is taken
      if (accept_c) begin
        s1_q       <= s1_d;
        acc_cnt_q  <= acc_cnt_q + CNT_W'(1);
        in_ready_q <= (acc_cnt_q + CNT_W'(1)) < count_q;
      end

      if (s1_valid_q) begin
        we_q     <= 1'b1;
        wdata_q  <= act_d;
        waddr_q  <= pack_waddr(bank_q, row_q);
        row_q    <= row_q + ROW_W'(1);
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            bank_q    <= bank;
            row_q     <= base_idx;
            count_q   <= count;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            busy_q    <= 1'b1;
            if (count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc_cnt_q == count_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid_q && (wr_cnt_q == count_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign wdata    = wdata_q;
  assign waddr    = waddr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_act_writeback.sv
// Scoreboard bench for act_writeback (SHIFT=8): driver pushes expected writes on
// accept, a negedge monitor pops and compares on every we cycle.
module tb_act_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bank;
  logic [7:0]  base_idx;
  logic [8:0]  count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] waddr;
  logic        busy;
  logic        done;

  act_writeback #(.SHIFT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bank(bank), .base_idx(base_idx),
    .count(count), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .we(we), .wdata(wdata), .waddr(waddr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] dir_d[$];
  logic [15:0] dir_a[$];
  logic [31:0] dir_w[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_we_cyc = -10;
  int we_cnt = 0;
  int burst_len = 0;
  logic cur_bank = 1'b0;
  int cur_base = 0;
  int cur_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: round half up, floor shift by 8, optional ReLU, clamp to int16
  function automatic logic [15:0] model_act(input logic [31:0] x);
    longint v = longint'($signed(x)) + 128;
    longint q;
    q = (v >= 0) ? v / 256 : -((-v + 255) / 256);
`ifdef ACT_WRITEBACK_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  function automatic logic [15:0] model_addr(input logic b, input int row);
    int r = row % 256;
    return 16'(int'(b) * 32768 + r * 8);
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom);
      1:       return 32'($urandom_range(0, 1 << 20)) - 32'd524288;
      2:       return 32'd8388480 + 32'($urandom_range(0, 512)) - 32'd256;
      default: return 32'hFF7FFF80 + 32'($urandom_range(0, 512)) - 32'd256;
    endcase
  endfunction

  // Monitor: every we must match the oldest expectation, two cycles after accept
  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wdata", 32'(wdata), 32'(mon_e.d));
        check("waddr", 32'(waddr), 32'(mon_e.a));
        check("latency", 32'(cyc), 32'(mon_e.cyc + 2));
      end
    end
    if (done === 1'b1 && burst_len > 0) begin
      check("done_after_last_we", 32'(cyc), 32'(last_we_cyc + 1));
      check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic send(input logic [31:0] d, input bit gap);
    exp_t ex;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ex.d   = (dir_d.size() > 0) ? dir_d.pop_front() : model_act(d);
        ex.a   = (dir_a.size() > 0) ? dir_a.pop_front() : model_addr(cur_bank, cur_base + cur_idx);
        ex.cyc = cyc;
        exp_q.push_back(ex);
        cur_idx++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_start(input logic b, input int base, input int n);
    start    = 1'b1;
    bank     = b;
    base_idx = 8'(base);
    count    = 9'(n);
    cur_bank = b; cur_base = base; cur_idx = 0; burst_len = n; we_cnt = 0;
    @(posedge clk); #1;
    start    = 1'b0;
    bank     = 1'($urandom);
    base_idx = 8'($urandom);
    count    = 9'($urandom);
  endtask

  task automatic burst(input logic b, input int base, input int n, input bit gaps,
                       input bit mid_start);
    bit got_done;
    issue_start(b, base, n);
    check("busy_after_start", 32'(busy), 32'd1);
    if (n == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("zero_busy_end", 32'(busy), 32'd0);
      check("zero_done_end", 32'(done), 32'd0);
      check("zero_no_we", 32'(we_cnt), 32'd0);
      return;
    end
    check("first_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == n / 2) begin
        start = 1'b1;
        count = 9'd200;
      end
      send((dir_w.size() > 0) ? dir_w.pop_front() : rand_word(),
           gaps && ($urandom_range(0, 2) == 0));
      start = 1'b0;
    end
    check("ready_low_after_count", 32'(in_ready), 32'd0);
    got_done = 1'b0;
    for (int t = 0; t < 20 && !got_done; t++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1'b1;
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("we_count", 32'(we_cnt), 32'(n));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; bank = 1'b0; base_idx = '0; count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: rounding, saturation, sign and row wrap inside bank 1
    dir_w = '{32'h0000_0180, 32'h0000_017F, 32'h7FFF_FFFF, 32'hFFFF_FF00};
    dir_a = '{16'h87F0, 16'h87F8, 16'h8000, 16'h8008};
`ifdef ACT_WRITEBACK_RELU_EN
    dir_d = '{16'h0002, 16'h0001, 16'h7FFF, 16'h0000};
`else
    dir_d = '{16'h0002, 16'h0001, 16'h7FFF, 16'hFFFF};
`endif
    burst(1'b1, 254, 4, 1'b0, 1'b0);

    dir_w = '{32'h8000_0000};
    dir_a = '{16'h0080};
`ifdef ACT_WRITEBACK_RELU_EN
    dir_d = '{16'h0000};
`else
    dir_d = '{16'h8000};
`endif
    burst(1'b0, 16, 1, 1'b0, 1'b0);

    burst(1'b0, 7, 0, 1'b0, 1'b0);
    burst(1'b1, 250, 8, 1'b1, 1'b1);

    // Reset after 2 of 5 accepts: word 1 still writes, word 2 must vanish
    issue_start(1'b0, 100, 5);
    send(rand_word(), 1'b0);
    send(rand_word(), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_busy", 32'(busy), 32'd0);
    burst(1'b0, 100, 5, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      burst(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(1, 24)),
            1'($urandom), 1'($urandom));
    end
    burst(1'b1, int'($urandom_range(0, 255)), 256, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/act_writeback.md
# act_writeback

Writeback stage directly upstream of the activation memory. Accepts 32-bit signed accumulator results from the MAC datapath over a valid/ready handshake, then rescales, rounds, optionally rectifies and saturates each result to 16 bits. Writes the results into consecutive activation-memory rows of a selected bank, using the memory's `{bank, row[7:0]}` addressing, and signals completion of each layer burst.

## Interface
Parameters:
- `SHIFT`, 8: arithmetic right shift applied to the accumulator (0–16); rounding offset is `1<<(SHIFT-1)` when `SHIFT>0`, none when `SHIFT==0`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `bank` in 1: target bank; driven on `waddr[15]`.
- `base_idx` in 8: first row index.
- `count` in 9: number of results in the burst, 0–256.
- `in_valid` in 1: accumulator word valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_data` in 32: signed accumulator value.
- `we` out 1: write strobe to activation memory.
- `wdata` out 16: signed activation value.
- `waddr` out 16: `{bank, 4'b0000, idx[7:0], 3'b000}`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: `start` latches `bank`, `base_idx`, `count`, clears the accept and write counters, then goes to RUN. If `count==0`, goes to DONE instead.
  - RUN: `in_ready = (accepted < count)`. When `accepted==count`, goes to DRAIN.
  - DRAIN: waits until the pipeline is empty and the final `we` has been issued, then goes to DONE.
  - DONE: asserts `done` for exactly one cycle, then returns to IDLE.
- Handshake: a transfer occurs on a rising edge with `in_valid && in_ready`. `in_data` need not be held once accepted. `in_ready` depends only on the FSM state and the accept count, never on `in_valid`.
- Stage 1 (on accept):
  - `r = (sext33(in_data) + round_off) >>> SHIFT`, computed in 33 bits.
- Stage 2:
  - Rectify (see Configuration).
  - Saturate to [-32768, 32767].
  - Register `wdata` and `waddr`, and pulse `we`.
- Address:
  - Row index starts at `base_idx` and increments by 1 per write.
  - Wraps 255→0 inside the same bank; `bank` is never changed by wrap.
- The memory provides no backpressure. Every accepted word produces exactly one `we` cycle.
- `start` outside IDLE is ignored. Latched command fields do not change until the next IDLE.

## Timing
- Reset values:
  - `in_ready=0`, `we=0`, `wdata=0`, `waddr=0`, `busy=0`, `done=0`.
  - State IDLE; counters 0.
- Latency: a word accepted at edge k drives `we`, `wdata` and `waddr` valid in the cycle after edge k+1 (2 cycles).
- Throughput: one word per cycle with no bubbles.
- First `in_ready` is high in the cycle after the `start` edge.
- `done` is high in the cycle immediately after the last `we` cycle. With `count==0`, `done` is high in the cycle after `start`, and no `we` is issued.
- `we` is high for one cycle per word. `wdata` and `waddr` hold their last values when `we=0`.
- `rst` mid-burst: in-flight words are discarded and no further `we` is issued. All outputs take their reset values at the next edge.

## Configuration
- Macro: `ACT_WRITEBACK_RELU_EN`.
- Defined: any negative stage-1 result becomes 0 before saturation (ReLU), so `wdata` range is 0–32767.
- Undefined: linear saturating path, so negative values saturate to -32768 minimum.

## Structure
- Shared package `act_pkg`:
  - `ACT_W=16`, `ACC_W=32`, `ROW_W=8`.
  - Helper function for the `waddr` packing `{bank, 4'b0, row, 3'b0}`, reused by readers of the activation memory.
  - State enum `wb_state_t` {IDLE, RUN, DRAIN, DONE}.
- One sub-module: `act_quant`, the combinational round/shift/ReLU/saturate, used by stage 1/2. The FSM, counters and pipeline registers live in `act_writeback`.

## Test plan
All scenarios use `SHIFT=8`.
- `in_data=0x00000180` (384) → `wdata=0x0002` (1.5 rounds up). `in_data=0x0000017F` → `0x0001`.
- `in_data=0x7FFFFFFF` → `wdata=0x7FFF`. `in_data=0x80000000` → `0x0000` with RELU_EN, `0x8000` without.
- `in_data=0xFFFFFF00` (-256) → `0x0000` with RELU_EN, `0xFFFF` without.
- `bank=1`, `base_idx=254`, `count=4`, `in_valid` held high:
  - `waddr` sequence 0x87F0, 0x87F8, 0x8000, 0x8008 on 4 consecutive `we` cycles.
  - `done` in the next cycle.
  - `in_ready` low after 4 accepts.
- `count=0` → `busy` for 1 cycle, `done` pulses, no `we`. `start` pulsed during RUN → ignored, burst length unchanged.
- `rst` asserted after 2 of 5 accepts → next cycle all outputs 0, no further `we`. A fresh `start` then runs a full 5-word burst correctly.
